aes_iter_cipher: RTL and testbench
==================================

# aes_iter_cipher

Iterative, parametrised AES encryption engine that runs one full cipher round per clock on a single 128-bit state register. It covers AES-128/192/256 through the NUM_ROUNDS parameter and implements the initial AddRoundKey and a final round without MixColumns. Blocks enter and leave on ready/valid handshakes. Round keys come from an external key-expansion store, indexed by this block. It sits between the block-input buffer and the ciphertext sink, and reuses the existing sub_bytes, shift_rows, mix_columns and add_round_key datapath blocks.

## Interface
- NUM_ROUNDS, default 10, meaning cipher rounds; legal values 10 (AES-128), 12 (AES-192), 14 (AES-256); any other value is an elaboration error.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  data_in holds a plaintext block.
- in_ready  out  1  engine accepts a block; high only in IDLE.
- data_in  in  [0:127]  plaintext; byte 0 at bits 0:7, column-major as in FIPS-197.
- rk_idx  out  4  index of the round key requested this cycle (0..NUM_ROUNDS).
- rk  in  [0:127]  round key rk_idx; combinational lookup, valid in the same cycle.
- out_valid  out  1  data_out holds a ciphertext block.
- out_ready  in  1  sink accepts data_out.
- data_out  out  [0:127]  ciphertext; same byte order as data_in.
- busy  out  1  high in ROUND or DONE.

## Operation
- States: IDLE, ROUND, DONE. Round counter r is 4 bits.
- IDLE: rk_idx=0, in_ready=1.
  - On in_valid&&in_ready: state <= data_in ^ rk, r <= 1, go to ROUND.
- ROUND: rk_idx=r.
  - r<NUM_ROUNDS: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk), r <= r+1.
  - r==NUM_ROUNDS: MixColumns is bypassed, state <= result, go to DONE.
- DONE: out_valid=1, data_out=state, rk_idx=NUM_ROUNDS.
  - On out_ready: go to IDLE.
  - data_out and out_valid stay stable until accepted.
- Outputs never combinationally depend on out_ready or in_valid. in_ready, out_valid and busy decode state only.
- No input is accepted in DONE. The next block is accepted in IDLE only.
- rst at any point, including mid-ROUND or in DONE with out_ready low, discards the block with no partial output. After the reset edge:
  - state IDLE, r=0
  - data_out=0, out_valid=0, in_ready=1, busy=0, rk_idx=0
- rst has priority over any handshake in the same cycle.

## Timing
- Accept on edge T. Rounds run on edges T+1..T+NUM_ROUNDS. out_valid is high from the cycle after edge T+NUM_ROUNDS.
- Latency accept→out_valid: NUM_ROUNDS cycles (10/12/14).
- With out_ready tied high, minimum initiation interval is NUM_ROUNDS+2 cycles (12/14/16).
- rk must settle in the cycle rk_idx is presented. rk_idx is registered-state-derived (glitch-free), so a synchronous ROM or register file read combinationally is fine.
- The critical path is one full round: SubBytes + ShiftRows + MixColumns + XOR + final-round mux.

## Structure
- Package aes_pkg:
  - block_t (logic [0:127])
  - the state enum
  - AES128_ROUNDS / AES192_ROUNDS / AES256_ROUNDS constants
  - the rk index width constant
- One sub-module, aes_round_comb: a combinational round with input final_round that bypasses mix_columns. It wraps the existing sub_bytes, shift_rows, mix_columns and add_round_key instances.
- aes_iter_cipher holds only the FSM, counter, state register and handshake logic.

## Test plan
- NUM_ROUNDS=10, the bench key-expansion model supplies rk. Plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → data_out 3925841d02dc09fbdc118597196a0b32, exactly 10 cycles after accept.
- NUM_ROUNDS=10, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a. All-zero plaintext and key → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- NUM_ROUNDS=12, key 000102…1617, same plaintext → dda97ca4864cdfe06eaf70a0ec0d7191. NUM_ROUNDS=14, key 000102…1e1f → 8ea2b7ca516745bfeafc49904b496089. Latency is 12 and 14 cycles respectively.
- Backpressure: hold out_ready low for 5 cycles in DONE, with in_valid high throughout → data_out stable, in_ready=0, no second block accepted. Release out_ready → second block accepted on the next IDLE cycle and its result is correct.
- rk_idx sequence check: rk_idx=0 at accept, then 1..NUM_ROUNDS once each, then held at NUM_ROUNDS in DONE.
- Assert rst at round 5 → next cycle: out_valid=0, data_out=0, in_ready=1. A fresh block afterwards yields the correct ciphertext and no stale output appears.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block type, control-state encoding, round-count
// constants, round-key index width, and the byte-level S-box / GF(2^8)
// helpers used by the datapath blocks.
// No ports (package).
package aes_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned AES192_ROUNDS = 12;
    localparam int unsigned AES256_ROUNDS = 14;

    // Wide enough to index round keys 0..AES256_ROUNDS.
    localparam int unsigned RK_IDX_W = 4;

    // Byte 0 sits at bits 0:7; bytes are column-major (byte i = row i%4, col i/4).
    typedef logic [0:127] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: XORs the state with a round key.
// Ports: din  - input state
//        rk   - round key
//        dout - keyed state
module add_round_key
    import aes_pkg::*;
(
    input  block_t din,
    input  block_t rk,
    output block_t dout
);

    assign dout = din ^ rk;

endmodule

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round built from the shared datapath
// blocks. final_round bypasses MixColumns for the last round.
// Ports: state_in    - state entering the round
//        rk          - round key for this round
//        final_round - 1 = skip MixColumns
//        state_out   - state leaving the round
module aes_round_comb
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t rk,
    input  logic   final_round,
    output block_t state_out
);

    block_t sb_out;
    block_t sr_out;
    block_t mc_out;
    block_t ark_in;

    sub_bytes u_sub_bytes (
        .din  (state_in),
        .dout (sb_out)
    );

    shift_rows u_shift_rows (
        .din  (sb_out),
        .dout (sr_out)
    );

    mix_columns u_mix_columns (
        .din  (sr_out),
        .dout (mc_out)
    );

    assign ark_in = final_round ? sr_out : mc_out;

    add_round_key u_add_round_key (
        .din  (ark_in),
        .rk   (rk),
        .dout (state_out)
    );

endmodule

// File: rtl/mix_columns.sv
// MixColumns: multiplies each 4-byte column by the fixed AES matrix
// {02 03 01 01} circulant over GF(2^8).
// Ports: din  - input state
//        dout - mixed state
module mix_columns
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        dout = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            dout[32*c +: 32] = mix_col(din[32*c +: 32]);
        end
    end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state is rotated left by r bytes.
// Ports: din  - input state
//        dout - shifted state
module shift_rows
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    always_comb begin
        dout = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                dout[8*(4*c + r) +: 8] = din[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: applies the AES S-box to each of the 16 state bytes.
// Ports: din  - input state
//        dout - substituted state
module sub_bytes
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            dout[8*i +: 8] = sbox(din[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption engine: one full round per clock on a single
// 128-bit state register. NUM_ROUNDS selects AES-128/192/256 (10/12/14).
// Ports: clk, rst       - clock, synchronous active-high reset
//        in_valid/in_ready, data_in   - plaintext input handshake
//        rk_idx, rk     - round-key index out, round key in (same cycle)
//        out_valid/out_ready, data_out - ciphertext output handshake
//        busy           - a block is in flight or awaiting acceptance
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:127]        data_in,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [0:127]        rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:127]        data_out,
    output logic                busy
);

    if (NUM_ROUNDS != AES128_ROUNDS && NUM_ROUNDS != AES192_ROUNDS &&
        NUM_ROUNDS != AES256_ROUNDS) begin : g_bad_num_rounds
        $error("aes_iter_cipher: NUM_ROUNDS must be 10, 12 or 14");
    end

    localparam logic [RK_IDX_W-1:0] LAST_ROUND = RK_IDX_W'(NUM_ROUNDS);

    state_e                fsm_q, fsm_d;
    logic [RK_IDX_W-1:0]   r_q, r_d;
    block_t                state_q, state_d;
    block_t                round_out;
    logic                  final_round;

    assign final_round = (r_q == LAST_ROUND);

    aes_round_comb u_round (
        .state_in    (state_q),
        .rk          (rk),
        .final_round (final_round),
        .state_out   (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        r_d     = r_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    state_d = data_in ^ rk;
                    r_d     = RK_IDX_W'(1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                if (final_round) begin
                    fsm_d = ST_DONE;
                end else begin
                    r_d = r_q + RK_IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                    r_d   = '0;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
                r_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            r_q     <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            r_q     <= r_d;
            state_q <= state_d;
        end
    end

    // All outputs decode registered state only.
    always_comb begin
        in_ready  = (fsm_q == ST_IDLE);
        out_valid = (fsm_q == ST_DONE);
        busy      = (fsm_q == ST_ROUND) || (fsm_q == ST_DONE);
        data_out  = (fsm_q == ST_DONE) ? state_q : '0;
        case (fsm_q)
            ST_ROUND: rk_idx = r_q;
            ST_DONE:  rk_idx = LAST_ROUND;
            default:  rk_idx = '0;
        endcase
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Self-checking bench for aes_iter_cipher: three instances (10/12/14 rounds)
// fed by a key-expansion model; expected ciphertexts are queued at accept
// and compared when out_valid rises.
module tb_aes_iter_cipher;
    import aes_pkg::*;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    block_t     data_in   [NI];
    logic [3:0] rk_idx    [NI];
    block_t     rk        [NI];
    logic       out_valid [NI];
    logic       out_ready [NI];
    block_t     data_out  [NI];
    logic       busy      [NI];

    block_t     rks [NI][16];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] inst;
        block_t     exp;
    } sb_t;
    sb_t sb_q[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_iter_cipher #(.NUM_ROUNDS(10 + 2*g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
            .rk_idx    (rk_idx[g]),
            .rk        (rk[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g]),
            .busy      (busy[g])
        );
        always_comb rk[g] = rks[g][rk_idx[g]];
    end

    // FIPS-197 key expansion; nk = key length in 32-bit words.
    task automatic load_keys(input int i, input logic [0:255] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int k = 0; k < nk; k++) w[k] = key[32*k +: 32];
        for (int k = nk; k < 4*(nk + 7); k++) begin
            t = w[k-1];
            if (k % nk == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
                    ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && k % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[k] = w[k-nk] ^ t;
        end
        for (int j = 0; j < nk + 7; j++)
            rks[i][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Presents a block and returns just after the accepting edge.
    task automatic drive_block(input int i, input block_t pt, input block_t exp,
                               output bit idx0_ok);
        @(negedge clk);
        data_in[i]  = pt;
        in_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !in_ready[i]; n++) @(negedge clk);
        idx0_ok = (rk_idx[i] === 4'd0) && (in_ready[i] === 1'b1);
        @(posedge clk);
        sb_q.push_back('{inst: 2'(i), exp: exp});
    endtask

    // Called right after the accepting edge; returns on the first negedge
    // with out_valid high. lat = number of edges after the accept edge.
    task automatic wait_done(input int i, output int lat, output bit seq_ok);
        int nr;
        nr     = 10 + 2*i;
        lat    = -1;
        seq_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) in_valid[i] = 1'b0;
            if (out_valid[i] === 1'b1) begin
                lat = k;
                break;
            end
            if (rk_idx[i] !== 4'(k + 1) || busy[i] !== 1'b1) seq_ok = 1'b0;
        end
        if (lat < 0 || rk_idx[i] !== 4'(nr)) seq_ok = 1'b0;
    endtask

    task automatic release_out(input int i);
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
    endtask

    function automatic block_t pop_exp(input int i);
        sb_t e;
        if (sb_q.size() == 0) return 'x;
        e = sb_q.pop_front();
        if (int'(e.inst) != i) return 'x;
        return e.exp;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || busy[i] !== 1'b0 ||
                rk_idx[i] !== 4'd0 || data_out[i] !== '0) begin
                errors++;
                $display("FAIL reset_state inst%0d got ov=%b ir=%b busy=%b idx=%0d dout=%h want 0 1 0 0 0",
                         i, out_valid[i], in_ready[i], busy[i], rk_idx[i], data_out[i]);
            end
        end
    endtask

    task automatic test_aes128();
        block_t       pts [3];
        logic [0:255] keys[3];
        block_t       cts [3];
        block_t       exp;
        bit           idx0_ok, seq_ok;
        int           lat;
        pts[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        keys[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        cts[0]  = 128'h3925841d02dc09fbdc118597196a0b32;
        pts[1]  = 128'h00112233445566778899aabbccddeeff;
        keys[1] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        cts[1]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pts[2]  = '0;
        keys[2] = '0;
        cts[2]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        for (int v = 0; v < 3; v++) begin
            load_keys(0, keys[v], 4);
            drive_block(0, pts[v], cts[v], idx0_ok);
            wait_done(0, lat, seq_ok);
            checks++;
            if (!idx0_ok) begin
                errors++;
                $display("FAIL aes128_accept_idx v%0d got bad rk_idx/in_ready at accept want idx 0 ready 1", v);
            end
            checks++;
            if (lat != 10) begin
                errors++;
                $display("FAIL aes128_latency v%0d got %0d want 10", v, lat);
            end
            checks++;
            if (!seq_ok) begin
                errors++;
                $display("FAIL aes128_rk_seq v%0d got out-of-order rk_idx (now %0d) want 1..10 then 10", v, rk_idx[0]);
            end
            exp = pop_exp(0);
            checks++;
            if (data_out[0] !== exp) begin
                errors++;
                $display("FAIL aes128_ct v%0d got %h want %h", v, data_out[0], exp);
            end
            release_out(0);
            checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL aes128_release v%0d got ov=%b ir=%b busy=%b want 0 1 0",
                         v, out_valid[0], in_ready[0], busy[0]);
            end
        end
    endtask

    task automatic test_long_keys();
        logic [0:255] keys[3];
        block_t       cts [3];
        block_t       exp;
        bit           idx0_ok, seq_ok;
        int           lat;
        keys[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        cts[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        cts[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int i = 1; i < NI; i++) begin
            load_keys(i, keys[i], 4 + 2*i);
            drive_block(i, 128'h00112233445566778899aabbccddeeff, cts[i], idx0_ok);
            wait_done(i, lat, seq_ok);
            checks++;
            if (lat != 10 + 2*i || !seq_ok || !idx0_ok) begin
                errors++;
                $display("FAIL long_key_timing nr%0d got lat=%0d seq_ok=%0b idx0_ok=%0b want lat=%0d 1 1",
                         10 + 2*i, lat, seq_ok, idx0_ok, 10 + 2*i);
            end
            exp = pop_exp(i);
            checks++;
            if (data_out[i] !== exp) begin
                errors++;
                $display("FAIL long_key_ct nr%0d got %h want %h", 10 + 2*i, data_out[i], exp);
            end
            release_out(i);
        end
    endtask

    task automatic test_back_to_back();
        block_t exp;
        bit     idx0_ok, seq_ok;
        int     lat;
        load_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        drive_block(0, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, idx0_ok);
        wait_done(0, lat, seq_ok);
        // Second block waits with in_valid high while the sink stalls.
        data_in[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        in_valid[0] = 1'b1;
        load_keys(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        exp = pop_exp(0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (data_out[0] !== exp || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 ||
                rk_idx[0] !== 4'd10) begin
                errors++;
                $display("FAIL backpressure_hold c%0d got dout=%h ov=%b ir=%b idx=%0d want %h 1 0 10",
                         c, data_out[0], out_valid[0], in_ready[0], rk_idx[0], exp);
            end
            @(negedge clk);
        end
        release_out(0);
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || rk_idx[0] !== 4'd0) begin
            errors++;
            $display("FAIL backpressure_idle got ir=%b ov=%b idx=%0d want 1 0 0",
                     in_ready[0], out_valid[0], rk_idx[0]);
        end
        @(posedge clk);
        sb_q.push_back('{inst: 2'd0, exp: 128'h3925841d02dc09fbdc118597196a0b32});
        wait_done(0, lat, seq_ok);
        checks++;
        if (lat != 10 || !seq_ok) begin
            errors++;
            $display("FAIL backpressure_second_timing got lat=%0d seq_ok=%0b want 10 1", lat, seq_ok);
        end
        exp = pop_exp(0);
        checks++;
        if (data_out[0] !== exp) begin
            errors++;
            $display("FAIL backpressure_second_ct got %h want %h", data_out[0], exp);
        end
        release_out(0);
    endtask

    task automatic test_reset_during_block();
        block_t exp;
        bit     idx0_ok, seq_ok, found;
        int     lat;
        sb_t    dropped;
        load_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        drive_block(0, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, idx0_ok);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
            if (rk_idx[0] === 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midround_reach got rk_idx=%0d want 5 within budget", rk_idx[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dropped = sb_q.pop_back();
        checks++;
        if (out_valid[0] !== 1'b0 || data_out[0] !== '0 || in_ready[0] !== 1'b1 ||
            busy[0] !== 1'b0 || rk_idx[0] !== 4'd0) begin
            errors++;
            $display("FAIL midround_reset got ov=%b dout=%h ir=%b busy=%b idx=%0d want 0 0 1 0 0",
                     out_valid[0], data_out[0], in_ready[0], busy[0], rk_idx[0]);
        end
        drive_block(0, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, idx0_ok);
        wait_done(0, lat, seq_ok);
        checks++;
        if (lat != 10 || !seq_ok) begin
            errors++;
            $display("FAIL after_reset_timing got lat=%0d seq_ok=%0b want 10 1", lat, seq_ok);
        end
        exp = pop_exp(0);
        checks++;
        if (data_out[0] !== exp) begin
            errors++;
            $display("FAIL after_reset_ct got %h want %h", data_out[0], exp);
        end
        // Reset while DONE and the sink is stalled discards the result.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || data_out[0] !== '0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL done_reset got ov=%b dout=%h ir=%b want 0 0 1",
                     out_valid[0], data_out[0], in_ready[0]);
        end
        if (dropped.inst != 2'd0) $display("note: unexpected dropped entry");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            data_in[i]   = '0;
            for (int j = 0; j < 16; j++) rks[i][j] = '0;
        end
        test_reset();
        test_aes128();
        test_long_keys();
        test_back_to_back();
        test_reset_during_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
